// File: rtl/commit_trace_buffer.sv
// Circular trace of retired instructions; an accepted retire is visible right after its edge and is popped on out_valid & out_ready.
// When full, the new entry is dropped (WRAP=0) or the oldest is overwritten (WRAP=1); either case sets the sticky overflow flag.
module commit_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      retire_valid,
  input  logic [DATA_W-1:0]         retire_pc,
  input  logic                      retire_halt,
  input  logic                      retire_regwrite,
  input  logic [REG_W-1:0]          retire_reg,
  input  logic [DATA_W-1:0]         retire_wdata,
  input  logic                      retire_memwrite,
  input  logic [DATA_W-1:0]         retire_memaddr,
  input  logic [DATA_W-1:0]         retire_memdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_inum,
  output logic [DATA_W-1:0]         out_pc,
  output logic [1:0]                out_kind,
  output logic [REG_W-1:0]          out_reg,
  output logic [DATA_W-1:0]         out_value,
  output logic [DATA_W-1:0]         out_addr,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      halted
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic WRAP_EN = (WRAP != 0);
  localparam logic [1:0] K_NOP = 2'd0, K_REG = 2'd1, K_ST = 2'd2, K_HALT = 2'd3;

  logic [31:0]       inum_mem  [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [1:0]        kind_mem  [DEPTH];
  logic [REG_W-1:0]  reg_mem   [DEPTH];
  logic [DATA_W-1:0] value_mem [DEPTH];
  logic [DATA_W-1:0] addr_mem  [DEPTH];

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      inum_ctr;
  logic             ovf_q, halted_q;

  logic accept, pop, full, write, overwrite, lost, inc;
  logic [1:0] new_kind;

  always_comb begin
    accept    = retire_valid & ~halted_q;
    pop       = (cnt != '0) & out_ready;
    full      = (cnt == FULL_CNT);
    lost      = accept & full & ~pop;
    write     = accept & (~full | pop | WRAP_EN);
    // Overwrite on a full buffer consumes the oldest slot, so the head moves too.
    overwrite = lost & WRAP_EN;
    inc       = write & ~overwrite;
    new_kind  = K_NOP;
    if (retire_halt)          new_kind = K_HALT;
    else if (retire_regwrite) new_kind = K_REG;
    else if (retire_memwrite) new_kind = K_ST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      inum_ctr <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (accept)               inum_ctr <= inum_ctr + 32'd1;
      if (accept & retire_halt) halted_q <= 1'b1;
      if (lost)                 ovf_q    <= 1'b1;
      if (write)                wptr     <= wptr + PTR_W'(1);
      if (pop | overwrite)      rptr     <= rptr + PTR_W'(1);
      if (inc & ~pop)           cnt      <= cnt + CNT_W'(1);
      else if (pop & ~inc)      cnt      <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (write & ~rst) begin
      inum_mem[wptr]  <= inum_ctr;
      pc_mem[wptr]    <= retire_pc;
      kind_mem[wptr]  <= new_kind;
      reg_mem[wptr]   <= retire_reg;
      value_mem[wptr] <= retire_regwrite ? retire_wdata : retire_memdata;
      addr_mem[wptr]  <= retire_memaddr;
    end
  end

  always_comb begin
    out_valid = (cnt != '0);
    out_inum  = inum_mem[rptr];
    out_pc    = pc_mem[rptr];
    out_kind  = kind_mem[rptr];
    out_reg   = reg_mem[rptr];
    out_value = value_mem[rptr];
    out_addr  = addr_mem[rptr];
    count     = cnt;
    overflow  = ovf_q;
    halted    = halted_q;
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench: one default-size instance plus two DEPTH=4 instances (drop / overwrite) sharing stimulus.
module tb_commit_trace_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, retire_valid, retire_halt, retire_regwrite, retire_memwrite, out_ready;
  logic [31:0] retire_pc, retire_wdata, retire_memaddr, retire_memdata;
  logic [4:0]  retire_reg;

  logic        v16, v4d, v4w;
  logic [31:0] inum16, inum4d, inum4w, pc16, pc4d, pc4w, val16, val4d, val4w, addr16, addr4d, addr4w;
  logic [1:0]  kind16, kind4d, kind4w;
  logic [4:0]  reg16, reg4d, reg4w;
  logic [4:0]  cnt16;
  logic [2:0]  cnt4d, cnt4w;
  logic        ovf16, ovf4d, ovf4w, hlt16, hlt4d, hlt4w;

  commit_trace_buffer dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_halt(retire_halt),
    .retire_regwrite(retire_regwrite), .retire_reg(retire_reg), .retire_wdata(retire_wdata),
    .retire_memwrite(retire_memwrite), .retire_memaddr(retire_memaddr), .retire_memdata(retire_memdata),
    .out_valid(v16), .out_ready(out_ready), .out_inum(inum16), .out_pc(pc16), .out_kind(kind16),
    .out_reg(reg16), .out_value(val16), .out_addr(addr16), .count(cnt16), .overflow(ovf16), .halted(hlt16));

  commit_trace_buffer #(.DEPTH(4), .WRAP(0)) u4d (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_halt(retire_halt),
    .retire_regwrite(retire_regwrite), .retire_reg(retire_reg), .retire_wdata(retire_wdata),
    .retire_memwrite(retire_memwrite), .retire_memaddr(retire_memaddr), .retire_memdata(retire_memdata),
    .out_valid(v4d), .out_ready(out_ready), .out_inum(inum4d), .out_pc(pc4d), .out_kind(kind4d),
    .out_reg(reg4d), .out_value(val4d), .out_addr(addr4d), .count(cnt4d), .overflow(ovf4d), .halted(hlt4d));

  commit_trace_buffer #(.DEPTH(4), .WRAP(1)) u4w (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_halt(retire_halt),
    .retire_regwrite(retire_regwrite), .retire_reg(retire_reg), .retire_wdata(retire_wdata),
    .retire_memwrite(retire_memwrite), .retire_memaddr(retire_memaddr), .retire_memdata(retire_memdata),
    .out_valid(v4w), .out_ready(out_ready), .out_inum(inum4w), .out_pc(pc4w), .out_kind(kind4w),
    .out_reg(reg4w), .out_value(val4w), .out_addr(addr4w), .count(cnt4w), .overflow(ovf4w), .halted(hlt4w));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic h, input logic rw, input logic [4:0] r,
                        input logic [31:0] wd, input logic mw, input logic [31:0] ma, input logic [31:0] md);
    retire_pc = pc; retire_halt = h; retire_regwrite = rw; retire_reg = r; retire_wdata = wd;
    retire_memwrite = mw; retire_memaddr = ma; retire_memdata = md;
    retire_valid = 1'b1;
    tick();
    retire_valid = 1'b0; retire_halt = 1'b0; retire_regwrite = 1'b0; retire_memwrite = 1'b0;
  endtask

  task automatic nop(input logic [31:0] pc);
    retire(pc, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; retire_valid = 1'b0; retire_halt = 1'b0; retire_regwrite = 1'b0; retire_memwrite = 1'b0;
    retire_pc = '0; retire_wdata = '0; retire_memaddr = '0; retire_memdata = '0; retire_reg = '0;
    out_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_count", 64'(cnt16), 64'd0);
    chk("rst_valid", 64'(v16), 64'd0);
    chk("rst_ovf", 64'(ovf16), 64'd0);
    chk("rst_halted", 64'(hlt16), 64'd0);

    // Three retires held, then drained in order
    retire(32'h0, 1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 32'h0, 32'h0);
    retire(32'h4, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h40, 32'h22);
    nop(32'h8);
    chk("hold_count", 64'(cnt16), 64'd3);
    chk("reg_kind", 64'(kind16), 64'd1);
    chk("reg_inum", 64'(inum16), 64'd0);
    chk("reg_pc", 64'(pc16), 64'd0);
    chk("reg_idx", 64'(reg16), 64'd3);
    chk("reg_value", 64'(val16), 64'h11);
    out_ready = 1'b1;
    tick();
    chk("st_kind", 64'(kind16), 64'd2);
    chk("st_inum", 64'(inum16), 64'd1);
    chk("st_pc", 64'(pc16), 64'h4);
    chk("st_addr", 64'(addr16), 64'h40);
    chk("st_value", 64'(val16), 64'h22);
    tick();
    chk("nop_kind", 64'(kind16), 64'd0);
    chk("nop_inum", 64'(inum16), 64'd2);
    chk("nop_pc", 64'(pc16), 64'h8);
    tick();
    chk("drained_count", 64'(cnt16), 64'd0);
    chk("drained_valid", 64'(v16), 64'd0);

    // Push into empty buffer with out_ready high is stored, not bypassed
    nop(32'hC);
    chk("nobypass_count", 64'(cnt16), 64'd1);
    chk("nobypass_inum", 64'(inum16), 64'd3);
    tick();
    chk("nobypass_drain", 64'(cnt16), 64'd0);

    // Six retires into DEPTH=4: drop vs overwrite
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) nop(32'(4 * i));
    chk("drop_count", 64'(cnt4d), 64'd4);
    chk("drop_ovf", 64'(ovf4d), 64'd1);
    chk("wrap_count", 64'(cnt4w), 64'd4);
    chk("wrap_ovf", 64'(ovf4w), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drop_drain_inum", 64'(inum4d), 64'(i));
      chk("wrap_drain_inum", 64'(inum4w), 64'(i + 2));
      chk("wrap_drain_pc", 64'(pc4w), 64'(4 * (i + 2)));
      tick();
    end
    out_ready = 1'b0;
    chk("drop_empty", 64'(v4d), 64'd0);
    chk("wrap_empty", 64'(v4w), 64'd0);
    nop(32'h100);
    chk("drop_next_inum", 64'(inum4d), 64'd6);
    chk("drop_ovf_sticky", 64'(ovf4d), 64'd1);

    // Full buffer, push and pop every cycle
    do_reset();
    for (int i = 0; i < 4; i++) nop(32'(4 * i));
    chk("stream_full", 64'(cnt4d), 64'd4);
    out_ready = 1'b1;
    retire_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("stream_inum", 64'(inum4d), 64'(k));
      tick();
      chk("stream_count", 64'(cnt4d), 64'd4);
    end
    retire_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream_ovf", 64'(ovf4d), 64'd0);
    chk("stream_after", 64'(inum4d), 64'd10);

    // Halt: further retires ignored, halt recorded even when dropped
    do_reset();
    for (int i = 0; i < 4; i++) nop(32'(4 * i));
    retire(32'h20, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) nop(32'h30 + 32'(4 * i));
    chk("halt_flag", 64'(hlt16), 64'd1);
    chk("halt_count", 64'(cnt16), 64'd5);
    chk("halt_drop_flag", 64'(hlt4d), 64'd1);
    chk("halt_drop_count", 64'(cnt4d), 64'd4);
    chk("halt_drop_ovf", 64'(ovf4d), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("halt_drain_inum", 64'(inum16), 64'(i));
      tick();
    end
    chk("halt_kind", 64'(kind16), 64'd3);
    chk("halt_pc", 64'(pc16), 64'h20);
    chk("halt_inum", 64'(inum16), 64'd4);
    tick();
    chk("halt_last", 64'(cnt16), 64'd0);
    out_ready = 1'b0;
    nop(32'h50);
    chk("halt_ignored", 64'(cnt16), 64'd0);

    // Reset beats simultaneous push/pop while halted with count=5
    do_reset();
    for (int i = 0; i < 4; i++) nop(32'(4 * i));
    retire(32'h20, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("pre_rst_count", 64'(cnt16), 64'd5);
    rst = 1'b1; retire_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; retire_valid = 1'b0; out_ready = 1'b0;
    chk("post_rst_count", 64'(cnt16), 64'd0);
    chk("post_rst_valid", 64'(v16), 64'd0);
    chk("post_rst_halted", 64'(hlt16), 64'd0);
    chk("post_rst_ovf", 64'(ovf4d), 64'd0);
    nop(32'h60);
    chk("post_rst_inum", 64'(inum16), 64'd0);
    chk("post_rst_pc", 64'(pc16), 64'h60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
